// File: rtl/year_display_if.sv
`default_nettype none
// ============================================================================
//  Module      : year_display_if
//  Description : Display-side bus of the year display driver: enable,
//                blanking control, the four BCD year digits in, and the
//                multiplexed segment/anode/frame signals out.
//  Revision    : 1.0  initial release
// ============================================================================
interface year_display_if;
    logic       en;
    logic       blank_lz;
    logic [3:0] year_0;
    logic [3:0] year_1;
    logic [3:0] year_2;
    logic [3:0] year_3;
    logic [6:0] seg;
    logic [3:0] an;
    logic       frame;

    // Side that supplies the year and consumes the display pins.
    modport master (
        output en, blank_lz, year_0, year_1, year_2, year_3,
        input  seg, an, frame
    );

    // The display driver itself.
    modport slave (
        input  en, blank_lz, year_0, year_1, year_2, year_3,
        output seg, an, frame
    );
endinterface
`default_nettype wire

// File: rtl/year_display.sv
`default_nettype none
// ============================================================================
//  Module      : year_display
//  Description : Four-digit multiplexed seven-segment driver for the year.
//                Latches a coherent snapshot of the digits once per scan
//                frame, optional leading-zero blanking, dash for non-BCD.
//  Revision    : 1.0  initial release
// ============================================================================
module year_display #(
    parameter int SCAN_DIV = 50000
) (
    input  wire logic     clk,
    input  wire logic     rst,      // asynchronous, active-low
    year_display_if.slave bus
);
    localparam int                   c_CNT_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [c_CNT_W-1:0]   c_CNT_MAX = c_CNT_W'(SCAN_DIV - 1);
    localparam logic [6:0]           c_SEG_OFF = 7'h7F;
    localparam logic [3:0]           c_AN_OFF  = 4'b1111;

    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_idx;
    logic [3:0]         r_snap [4];
    logic               r_first;
    logic [6:0]         r_seg;
    logic [3:0]         r_an;
    logic               r_frame;

    logic [3:0]         w_year [4];
    logic               w_tick;
    logic               w_wrap;
    logic [3:0]         w_lz;
    logic               w_blank_slot;
    logic [3:0]         w_an_dec;
    logic [6:0]         w_seg_dec;

    // Active-low {g,f,e,d,c,b,a}; anything outside 0..9 shows a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'd0:    seg_decode = 7'h40;
            4'd1:    seg_decode = 7'h79;
            4'd2:    seg_decode = 7'h24;
            4'd3:    seg_decode = 7'h30;
            4'd4:    seg_decode = 7'h19;
            4'd5:    seg_decode = 7'h12;
            4'd6:    seg_decode = 7'h02;
            4'd7:    seg_decode = 7'h78;
            4'd8:    seg_decode = 7'h00;
            4'd9:    seg_decode = 7'h10;
            default: seg_decode = 7'h3F;
        endcase
    endfunction

    assign w_year[0] = bus.year_0;
    assign w_year[1] = bus.year_1;
    assign w_year[2] = bus.year_2;
    assign w_year[3] = bus.year_3;

    assign w_tick = (r_cnt == c_CNT_MAX);
    assign w_wrap = w_tick && (r_idx == 2'd3);

    // Decode the slot currently selected by idx from the held snapshot.
    always_comb begin
        w_lz[0]      = 1'b0;
        w_lz[1]      = (r_snap[3] == 4'd0) && (r_snap[2] == 4'd0) && (r_snap[1] == 4'd0);
        w_lz[2]      = (r_snap[3] == 4'd0) && (r_snap[2] == 4'd0);
        w_lz[3]      = (r_snap[3] == 4'd0);
        w_blank_slot = bus.blank_lz && w_lz[r_idx];
        w_an_dec     = w_blank_slot ? c_AN_OFF  : ~(4'b0001 << r_idx);
        w_seg_dec    = w_blank_slot ? c_SEG_OFF : seg_decode(r_snap[r_idx]);
    end

    // Scan counters, snapshot and registered display outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_first <= 1'b1;
            r_an    <= c_AN_OFF;
            r_seg   <= c_SEG_OFF;
            r_frame <= 1'b0;
            for (int k = 0; k < 4; k++) r_snap[k] <= 4'd0;
        end else if (!bus.en) begin
            // Snapshot is held so the last year survives a disable.
            r_cnt   <= '0;
            r_idx   <= 2'd0;
            r_first <= 1'b1;
            r_an    <= c_AN_OFF;
            r_seg   <= c_SEG_OFF;
            r_frame <= 1'b0;
        end else if (r_first) begin
            // Restart edge: take a fresh snapshot and show nothing yet; the
            // scan counters stay at zero so slot 0 then gets a full slot.
            r_first <= 1'b0;
            r_an    <= c_AN_OFF;
            r_seg   <= c_SEG_OFF;
            r_frame <= 1'b1;
            for (int k = 0; k < 4; k++) r_snap[k] <= w_year[k];
        end else begin
            r_cnt   <= w_tick ? '0 : r_cnt + 1'b1;
            if (w_tick) r_idx <= r_idx + 2'd1;
            r_an    <= w_an_dec;
            r_seg   <= w_seg_dec;
            r_frame <= w_wrap;
            if (w_wrap) begin
                for (int k = 0; k < 4; k++) r_snap[k] <= w_year[k];
            end
        end
    end

    assign bus.seg   = r_seg;
    assign bus.an    = r_an;
    assign bus.frame = r_frame;
endmodule
`default_nettype wire

// File: tb/tb_year_display.sv
`default_nettype none
// ============================================================================
//  Module      : tb_year_display
//  Description : Self-checking bench for year_display. A time-based model
//                (edges since the last restart -> slot/frame position)
//                predicts an/seg/frame every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_year_display;
    localparam int D = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    year_display_if bus ();

    year_display #(.SCAN_DIV(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state.
    logic [3:0] m_snap [4];
    bit         m_first;
    int         m_n;          // enabled edges since the snapshot restart
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_frame;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        logic [6:0] tbl [10];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        if (v > 4'd9) return 7'h3F;
        return tbl[v];
    endfunction

    // A slot is blank when blanking is on and it and every higher digit is zero.
    function automatic bit ref_blank(input int slot, input bit blz,
                                     input logic [3:0] s0, input logic [3:0] s1,
                                     input logic [3:0] s2, input logic [3:0] s3);
        int hi;
        if (!blz || slot == 0) return 1'b0;
        hi = 0;
        if (slot <= 1) hi += int'(s1);
        if (slot <= 2) hi += int'(s2);
        hi += int'(s3);
        return hi == 0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_snap[k] = 4'd0;
        m_first = 1'b1;
        m_n     = 0;
        e_an    = 4'b1111;
        e_seg   = 7'h7F;
        e_frame = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        checks++;
        assert (bus.an === e_an) else begin
            errors++;
            $error("FAIL %s an t=%0t observed=%b expected=%b", tag, $time, bus.an, e_an);
        end
        checks++;
        assert (bus.seg === e_seg) else begin
            errors++;
            $error("FAIL %s seg t=%0t observed=%h expected=%h", tag, $time, bus.seg, e_seg);
        end
        checks++;
        assert (bus.frame === e_frame) else begin
            errors++;
            $error("FAIL %s frame t=%0t observed=%b expected=%b", tag, $time, bus.frame, e_frame);
        end
    endtask

    task automatic set_year(input logic [15:0] y);
        bus.year_0 = y[3:0];
        bus.year_1 = y[7:4];
        bus.year_2 = y[11:8];
        bus.year_3 = y[15:12];
    endtask

    // One clock: predict from pre-edge inputs, clock, then compare.
    task automatic cyc(input string tag);
        logic [3:0] y [4];
        int         slot;
        y[0] = bus.year_0; y[1] = bus.year_1; y[2] = bus.year_2; y[3] = bus.year_3;
        if (!rst) begin
            model_reset();
        end else if (!bus.en) begin
            m_first = 1'b1;
            e_an = 4'b1111; e_seg = 7'h7F; e_frame = 1'b0;
        end else if (m_first) begin
            for (int k = 0; k < 4; k++) m_snap[k] = y[k];
            m_first = 1'b0;
            m_n = 0;
            e_an = 4'b1111; e_seg = 7'h7F; e_frame = 1'b1;
        end else begin
            slot = (m_n / D) % 4;
            if (ref_blank(slot, bus.blank_lz, m_snap[0], m_snap[1], m_snap[2], m_snap[3])) begin
                e_an = 4'b1111; e_seg = 7'h7F;
            end else begin
                e_an = 4'b1111; e_an[slot] = 1'b0;
                e_seg = ref_seg(m_snap[slot]);
            end
            e_frame = ((m_n % (4 * D)) == (4 * D - 1));
            if (e_frame) for (int k = 0; k < 4; k++) m_snap[k] = y[k];
            m_n++;
        end
        @(posedge clk);
        #1;
        check_outputs(tag);
        @(negedge clk);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(tag);
    endtask

    initial begin
        bus.en = 1'b1;
        bus.blank_lz = 1'b0;
        set_year(16'h2024);
        model_reset();
        #2 rst = 1'b0;
        #1 check_outputs("reset_state");
        @(negedge clk);
        run(2, "reset_hold");

        // Normal scan of 2024.
        rst = 1'b1;
        run(40, "scan_2024");

        // Coherent snapshot: 1999 then 2000 mid-frame.
        set_year(16'h1999);
        run(20, "load_1999");
        for (int i = 0; i < 32 && (m_n / D) % 4 != 1; i++) cyc("seek_idx1");
        set_year(16'h2000);
        run(36, "tear_2000");

        // Leading-zero blanking.
        bus.blank_lz = 1'b1;
        set_year(16'h0007);
        run(36, "lz_0007");
        set_year(16'h0000);
        run(36, "lz_0000");
        bus.blank_lz = 1'b0;
        run(20, "nolz_0000");

        // Invalid BCD in digit 2.
        bus.blank_lz = 1'b1;
        set_year(16'h0C00);
        run(36, "bcd_dash");

        // Enable toggle at idx 2, re-enable with a new year.
        bus.blank_lz = 1'b0;
        set_year(16'h5678);
        run(18, "pre_en");
        for (int i = 0; i < 32 && (m_n / D) % 4 != 2; i++) cyc("seek_idx2");
        run(1, "mid_slot2");
        bus.en = 1'b0;
        run(3, "en_low");
        set_year(16'h1234);
        bus.en = 1'b1;
        run(24, "reenable_1234");

        // Asynchronous reset between edges.
        #2 rst = 1'b0;
        model_reset();
        #1 check_outputs("async_reset");
        @(negedge clk);
        run(2, "async_hold");
        rst = 1'b1;
        set_year(16'h2024);
        run(24, "after_reset");

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            int r;
            int d;
            logic [3:0] v;
            r = int'($urandom_range(0, 99));
            if (r < 12) begin
                d = int'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0:       v = 4'($urandom_range(10, 15));
                    1, 2:    v = 4'd0;
                    default: v = 4'($urandom_range(0, 9));
                endcase
                case (d)
                    0: bus.year_0 = v;
                    1: bus.year_1 = v;
                    2: bus.year_2 = v;
                    default: bus.year_3 = v;
                endcase
            end else if (r < 16) begin
                bus.blank_lz = ~bus.blank_lz;
            end else if (r < 18) begin
                bus.en = ~bus.en;
            end
            cyc("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
